// File: rtl/m_areg_arbiter_if.sv
// ---------------------------------------------------------------------------
// m_areg_arbiter_if
//
// Bundles the two access-register request channels and the single local
// memory port that m_areg_arbiter shares between them.
//
// Parameter:
//   FLIT_W            width of an access-register message (default 176)
//
// Signals:
//   v_d_m_areg_flits  data-side request valid (level, held until done)
//   d_m_areg_flits    data-side message
//   v_i_m_areg_flits  instruction-side request valid (level)
//   i_m_areg_flits    instruction-side message
//   mem_ack           memory completed the current access (1-cycle pulse)
//   mem_req           access in progress on the memory port
//   mem_flits         latched message of the granted requester
//   mem_grant_id      0 = data side, 1 = instruction side
//   d_mem_done_access one-cycle done pulse to the data-side register
//   i_mem_done_access one-cycle done pulse to the instruction-side register
//   arb_busy          arbiter is not idle
//   err_timeout       sticky watchdog-expiry flag
//
// Modports:
//   master            the arbiter (drives the memory port and the strobes)
//   slave             the access registers / memory side
// ---------------------------------------------------------------------------
interface m_areg_arbiter_if #(
    parameter int FLIT_W = 176
);
    logic              v_d_m_areg_flits;
    logic [FLIT_W-1:0] d_m_areg_flits;
    logic              v_i_m_areg_flits;
    logic [FLIT_W-1:0] i_m_areg_flits;
    logic              mem_ack;
    logic              mem_req;
    logic [FLIT_W-1:0] mem_flits;
    logic              mem_grant_id;
    logic              d_mem_done_access;
    logic              i_mem_done_access;
    logic              arb_busy;
    logic              err_timeout;

    modport master (
        input  v_d_m_areg_flits,
        input  d_m_areg_flits,
        input  v_i_m_areg_flits,
        input  i_m_areg_flits,
        input  mem_ack,
        output mem_req,
        output mem_flits,
        output mem_grant_id,
        output d_mem_done_access,
        output i_mem_done_access,
        output arb_busy,
        output err_timeout
    );

    modport slave (
        output v_d_m_areg_flits,
        output d_m_areg_flits,
        output v_i_m_areg_flits,
        output i_m_areg_flits,
        output mem_ack,
        input  mem_req,
        input  mem_flits,
        input  mem_grant_id,
        input  d_mem_done_access,
        input  i_mem_done_access,
        input  arb_busy,
        input  err_timeout
    );
endinterface

// File: rtl/m_areg_arbiter.sv
// ---------------------------------------------------------------------------
// m_areg_arbiter
//
// Shares the single local memory port between the data-side and the
// instruction-side memory access registers. In IDLE one valid requester is
// chosen and its message is latched onto the memory port (REQ). The arbiter
// then waits for mem_ack or for the watchdog to expire and spends one cycle
// in DONE pulsing the winner's done strobe, which clears that register.
//
// Parameters:
//   FLIT_W   message width; must match the interface FLIT_W (default 176)
//   TIMEOUT  maximum REQ cycles before completion is forced (1..255)
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous, active-low reset
//   bus      m_areg_arbiter_if.master (request channels + memory port)
//
// Configuration macro:
//   M_AREG_ARB_RR_EN  defined   -> ties go to the side opposite last_grant
//                     undefined -> fixed priority, data side wins ties
// ---------------------------------------------------------------------------
module m_areg_arbiter #(
    parameter int FLIT_W  = 176,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    m_areg_arbiter_if.master      bus
);

`ifdef M_AREG_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    // 2-bit encoding; the spare code 2'b11 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    logic [7:0]        wdog;
    logic              last_grant;   // 0 = data side, 1 = instruction side

    logic              any_valid;
    logic              tie_pick_i;
    logic              pick_i;

    // ------------------------------------------------------------------
    // Winner selection (only consumed in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        tie_pick_i = 1'b0;
        pick_i     = 1'b0;
        any_valid  = bus.v_d_m_areg_flits | bus.v_i_m_areg_flits;

        // Round-robin hands a tie to the side that did not win last time;
        // fixed priority always hands it to the data side.
        tie_pick_i = RR_EN ? ~last_grant : 1'b0;

        if (bus.v_d_m_areg_flits && bus.v_i_m_areg_flits) begin
            pick_i = tie_pick_i;
        end else begin
            pick_i = bus.v_i_m_areg_flits;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: mem_flits is an ordinary register rather than a memory
            // array, so it is cleared with the rest of the state.
            state                 <= IDLE;
            wdog                  <= 8'd0;
            last_grant            <= 1'b1;
            bus.mem_req           <= 1'b0;
            bus.mem_flits         <= '0;
            bus.mem_grant_id      <= 1'b0;
            bus.d_mem_done_access <= 1'b0;
            bus.i_mem_done_access <= 1'b0;
            bus.arb_busy          <= 1'b0;
            bus.err_timeout       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in this block samples the pre-edge values.
            // Done strobes are single-cycle unless DONE is being entered.
            bus.d_mem_done_access <= 1'b0;
            bus.i_mem_done_access <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        bus.mem_flits    <= pick_i ? bus.i_m_areg_flits
                                                   : bus.d_m_areg_flits;
                        bus.mem_grant_id <= pick_i;
                        last_grant       <= pick_i;
                        wdog             <= 8'd0;
                        bus.mem_req      <= 1'b1;
                        bus.arb_busy     <= 1'b1;
                        state            <= REQ;
                    end
                end

                REQ: begin
                    // Ack takes precedence over a watchdog expiry in the
                    // same cycle, so err_timeout stays clear in that case.
                    if (bus.mem_ack || (wdog == WDOG_LAST)) begin
                        if (!bus.mem_ack) begin
                            bus.err_timeout <= 1'b1;
                        end
                        bus.mem_req           <= 1'b0;
                        bus.d_mem_done_access <= ~bus.mem_grant_id;
                        bus.i_mem_done_access <=  bus.mem_grant_id;
                        state                 <= DONE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end

                DONE: begin
                    // The served register drops its valid on this edge, so
                    // IDLE cannot grant it a second time.
                    bus.arb_busy <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    bus.mem_req  <= 1'b0;
                    bus.arb_busy <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_areg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_m_areg_arbiter
//
// Two arbiters are exercised side by side: unit 0 with TIMEOUT=12 and unit 1
// with TIMEOUT=4. A transaction-level model per unit predicts every output
// on every cycle; directed sequences add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_m_areg_arbiter;

    localparam int FW  = 176;
    localparam int T0  = 12;
    localparam int T1  = 4;

`ifdef M_AREG_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, index = unit
    logic [1:0]    v_d     = '0;
    logic [1:0]    v_i     = '0;
    logic [1:0]    mem_ack = '0;
    logic [FW-1:0] d_fl [2];
    logic [FW-1:0] i_fl [2];

    // Observed outputs, index = unit
    logic [1:0]    o_req, o_grant, o_d_done, o_i_done, o_busy, o_err;
    logic [FW-1:0] o_flits [2];

    int checks = 0;
    int errors = 0;

    m_areg_arbiter_if #(.FLIT_W(FW)) bus0 ();
    m_areg_arbiter_if #(.FLIT_W(FW)) bus1 ();

    assign bus0.v_d_m_areg_flits = v_d[0];
    assign bus0.d_m_areg_flits   = d_fl[0];
    assign bus0.v_i_m_areg_flits = v_i[0];
    assign bus0.i_m_areg_flits   = i_fl[0];
    assign bus0.mem_ack          = mem_ack[0];
    assign bus1.v_d_m_areg_flits = v_d[1];
    assign bus1.d_m_areg_flits   = d_fl[1];
    assign bus1.v_i_m_areg_flits = v_i[1];
    assign bus1.i_m_areg_flits   = i_fl[1];
    assign bus1.mem_ack          = mem_ack[1];

    assign o_req    = {bus1.mem_req,           bus0.mem_req};
    assign o_grant  = {bus1.mem_grant_id,      bus0.mem_grant_id};
    assign o_d_done = {bus1.d_mem_done_access, bus0.d_mem_done_access};
    assign o_i_done = {bus1.i_mem_done_access, bus0.i_mem_done_access};
    assign o_busy   = {bus1.arb_busy,          bus0.arb_busy};
    assign o_err    = {bus1.err_timeout,       bus0.err_timeout};
    assign o_flits[0] = bus0.mem_flits;
    assign o_flits[1] = bus1.mem_flits;

    m_areg_arbiter #(.FLIT_W(FW), .TIMEOUT(T0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    m_areg_arbiter #(.FLIT_W(FW), .TIMEOUT(T1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] rand_flit();
        logic [FW-1:0] f;
        f = '0;
        for (int w = 0; w < (FW + 31) / 32; w++) begin
            f = (f << 32) | FW'($urandom);
        end
        return f;
    endfunction

    function automatic int tmo(input int k);
        return (k == 0) ? T0 : T1;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference: one record per unit describing the
    // access in flight, how many memory cycles it has waited, and whether
    // this is its completion cycle.
    // ------------------------------------------------------------------
    typedef struct {
        bit            active;   // access on the memory port this cycle
        bit            strobe;   // completion cycle of the last access
        bit            side;     // requester of the current/last access
        bit            last;     // most recent winner
        bit            err;
        int            waited;   // memory cycles already spent
        logic [FW-1:0] flits;
    } acc_t;

    acc_t mdl [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mdl[k].active = 1'b0;
                mdl[k].strobe = 1'b0;
                mdl[k].side   = 1'b0;
                mdl[k].last   = 1'b1;
                mdl[k].err    = 1'b0;
                mdl[k].waited = 0;
                mdl[k].flits  = '0;
            end

            check($sformatf("u%0d mem_req", k),      o_req[k],    mdl[k].active);
            check($sformatf("u%0d grant_id", k),     o_grant[k],  mdl[k].side);
            check($sformatf("u%0d mem_flits", k),    o_flits[k],  mdl[k].flits);
            check($sformatf("u%0d d_done", k),       o_d_done[k], mdl[k].strobe && !mdl[k].side);
            check($sformatf("u%0d i_done", k),       o_i_done[k], mdl[k].strobe &&  mdl[k].side);
            check($sformatf("u%0d arb_busy", k),     o_busy[k],   mdl[k].active || mdl[k].strobe);
            check($sformatf("u%0d err_timeout", k),  o_err[k],    mdl[k].err);

            // Inputs are stable here, so they are what the next edge sees.
            if (rst) begin
                if (mdl[k].strobe) begin
                    mdl[k].strobe = 1'b0;
                end else if (mdl[k].active) begin
                    mdl[k].waited++;
                    if (mem_ack[k]) begin
                        mdl[k].active = 1'b0;
                        mdl[k].strobe = 1'b1;
                    end else if (mdl[k].waited == tmo(k)) begin
                        mdl[k].err    = 1'b1;
                        mdl[k].active = 1'b0;
                        mdl[k].strobe = 1'b1;
                    end
                end else if (v_d[k] || v_i[k]) begin
                    if (v_d[k] && v_i[k]) mdl[k].side = RR ? !mdl[k].last : 1'b0;
                    else                  mdl[k].side = v_i[k];
                    mdl[k].flits  = mdl[k].side ? i_fl[k] : d_fl[k];
                    mdl[k].last   = mdl[k].side;
                    mdl[k].active = 1'b1;
                    mdl[k].waited = 0;
                end
            end
        end
    end

    // One clock: note strobes seen this cycle, then act as the access
    // registers and memory just after the next rising edge.
    task automatic tick();
        logic [1:0] dd, di;
        @(negedge clk);
        dd = o_d_done;
        di = o_i_done;
        @(posedge clk);
        #1;
        v_d     = v_d & ~dd;
        v_i     = v_i & ~di;
        mem_ack = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1);
    end

    initial begin
        int gid [4];
        int gcyc [4];
        int ng, d_left, cnt;
        int exp_gid [4];

        d_fl[0] = '0; d_fl[1] = '0; i_fl[0] = '0; i_fl[1] = '0;

        // ---------------- reset ----------------
        repeat (3) tick();
        check("reset mem_req",   o_req,   2'b00);
        check("reset arb_busy",  o_busy,  2'b00);
        check("reset err",       o_err,   2'b00);
        check("reset mem_flits", o_flits[0], '0);
        rst = 1'b1;
        tick();

        // ---------------- tie with data side re-requesting ----------------
        // Data side requests three times in a row, instruction side once.
        if (RR) begin
            exp_gid[0] = 0; exp_gid[1] = 1; exp_gid[2] = 0; exp_gid[3] = 0;
        end else begin
            exp_gid[0] = 0; exp_gid[1] = 0; exp_gid[2] = 0; exp_gid[3] = 1;
        end
        v_d[0] = 1'b1; d_fl[0] = rand_flit();
        v_i[0] = 1'b1; i_fl[0] = rand_flit();
        d_left = 2;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            if (o_req[0]) begin
                gid[ng]  = int'(o_grant[0]);
                gcyc[ng] = c;
                ng++;
                mem_ack[0] = 1'b1;
            end
            tick();
            if (!v_d[0] && d_left > 0) begin
                v_d[0]  = 1'b1;
                d_fl[0] = rand_flit();
                d_left--;
            end
        end
        check("tie grant count", FW'(ng), FW'(4));
        for (int n = 0; n < ng && n < 4; n++) begin
            check($sformatf("tie grant %0d id", n), FW'(gid[n]), FW'(exp_gid[n]));
            if (n > 0) check($sformatf("tie grant %0d spacing", n), FW'(gcyc[n] - gcyc[n-1]), FW'(3));
        end
        repeat (3) tick();
        check("tie drained valids", {v_d[0], v_i[0]}, 2'b00);

        // ---------------- single data request, immediate ack ----------------
        v_d[0]  = 1'b1;
        d_fl[0] = {{(FW/16){16'hABCD}}};
        check("single c0 mem_req", o_req[0], 1'b0);
        tick();
        check("single c1 mem_req", o_req[0], 1'b1);
        check("single c1 flits",   o_flits[0], {{(FW/16){16'hABCD}}});
        check("single c1 grant",   o_grant[0], 1'b0);
        mem_ack[0] = 1'b1;
        tick();
        check("single c2 mem_req", o_req[0], 1'b0);
        check("single c2 d_done",  o_d_done[0], 1'b1);
        check("single c2 i_done",  o_i_done[0], 1'b0);
        tick();
        check("single c3 d_done",  o_d_done[0], 1'b0);
        check("single c3 valid",   v_d[0], 1'b0);

        // ---------------- delayed ack on instruction side ----------------
        v_i[0]  = 1'b1;
        i_fl[0] = rand_flit();
        tick();
        cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            cnt += int'(o_req[0]);
            if (n == 10) mem_ack[0] = 1'b1;
            tick();
        end
        check("delayed req cycles", FW'(cnt), FW'(10));
        check("delayed i_done",     o_i_done[0], 1'b1);
        check("delayed err",        o_err[0], 1'b0);
        tick();

        // ---------------- ack and watchdog in the same cycle (T=4) ----------------
        v_d[1]  = 1'b1;
        d_fl[1] = rand_flit();
        tick();
        cnt = 0;
        for (int n = 1; n <= 4; n++) begin
            cnt += int'(o_req[1]);
            if (n == 4) mem_ack[1] = 1'b1;
            tick();
        end
        check("ack@expiry req cycles", FW'(cnt), FW'(4));
        check("ack@expiry d_done",     o_d_done[1], 1'b1);
        check("ack@expiry err",        o_err[1], 1'b0);
        tick();

        // ---------------- timeout (T=4) ----------------
        v_i[1]  = 1'b1;
        i_fl[1] = rand_flit();
        tick();
        cnt = 0;
        while (o_req[1] && cnt < 20) begin
            cnt++;
            tick();
        end
        check("timeout req cycles", FW'(cnt), FW'(4));
        check("timeout i_done",     o_i_done[1], 1'b1);
        check("timeout err",        o_err[1], 1'b1);
        repeat (3) tick();
        check("timeout err sticky", o_err[1], 1'b1);

        // ---------------- reset during a wait ----------------
        v_d[0]  = 1'b1;
        d_fl[0] = rand_flit();
        repeat (3) tick();
        check("pre-reset mem_req", o_req[0], 1'b1);
        rst = 1'b0;
        #1;
        check("reset-mid mem_req",  o_req[0],   1'b0);
        check("reset-mid busy",     o_busy[0],  1'b0);
        check("reset-mid flits",    o_flits[0], '0);
        check("reset-mid err u1",   o_err[1],   1'b0);
        tick();
        check("reset-mid no done",  {o_d_done[0], o_i_done[0]}, 2'b00);
        check("reset-mid valid kept", v_d[0], 1'b1);
        rst = 1'b1;
        tick();
        check("regrant mem_req", o_req[0],   1'b1);
        check("regrant grant",   o_grant[0], 1'b0);
        mem_ack[0] = 1'b1;
        repeat (3) tick();

        // ---------------- randomized traffic on both units ----------------
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!v_d[k] && $urandom_range(2) == 0) begin
                    v_d[k]  = 1'b1;
                    d_fl[k] = rand_flit();
                end else if (v_d[k] && $urandom_range(15) == 0) begin
                    v_d[k] = 1'b0;
                end
                if (!v_i[k] && $urandom_range(2) == 0) begin
                    v_i[k]  = 1'b1;
                    i_fl[k] = rand_flit();
                end else if (v_i[k] && $urandom_range(15) == 0) begin
                    v_i[k] = 1'b0;
                end
                mem_ack[k] = ($urandom_range(3) == 0);
            end
            tick();
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
